jk_bank_seq: RTL and testbench

//  Command-driven sequencer for a bank of WIDTH JK flip-flop cells (bit i: J/K -> q_o[i]).

---
 rtl/jk_bank_seq.sv | 196 +++++++++++++++++++
 tb/tb_jk_bank_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_seq.sv
// Command sequencer driving a bank of JK flip-flop cells; every register/counter
// operation is expressed purely as per-bit J/K pairs (00 hold, 01 reset, 10 set, 11 toggle).
module jk_bank_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [CNT_W-1:0] cmd_len_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] q_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_CNT_UP = 3'd4;
  localparam logic [2:0] OP_CNT_DN = 3'd5;
  localparam logic [2:0] OP_SHL    = 3'd6;
  localparam logic [2:0] OP_HOLD   = 3'd7;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bank_q, bank_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] j_s, k_s;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

  // Per-bit J/K drive; a step is suppressed outright when abort is raised in EXEC.
  always_comb begin
    logic carry;
    j_s   = '0;
    k_s   = '0;
    carry = 1'b1;
    if ((state_q == ST_EXEC) && !abort_i) begin
      case (op_q)
        OP_LOAD: begin
          j_s = data_q;
          k_s = ~data_q;
        end
        OP_CLEAR: begin
          k_s = '1;
        end
        OP_SET: begin
          j_s = '1;
        end
        OP_TOGGLE: begin
          j_s = data_q;
          k_s = data_q;
        end
        OP_CNT_UP: begin
          for (int i = 0; i < WIDTH; i++) begin
            j_s[i] = carry;
            k_s[i] = carry;
            carry  = carry & bank_q[i];
          end
        end
        OP_CNT_DN: begin
          for (int i = 0; i < WIDTH; i++) begin
            j_s[i] = carry;
            k_s[i] = carry;
            carry  = carry & ~bank_q[i];
          end
        end
        OP_SHL: begin
          j_s = {bank_q[WIDTH-2:0], data_q[0]};
          k_s = ~{bank_q[WIDTH-2:0], data_q[0]};
        end
        OP_HOLD: begin
          j_s = '0;
          k_s = '0;
        end
        default: begin
          j_s = '0;
          k_s = '0;
        end
      endcase
    end else begin
      j_s = '0;
      k_s = '0;
    end
  end

  // JK cell update for the whole bank.
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < WIDTH; i++) begin
      bank_d[i] = jk_next(bank_q[i], j_s[i], k_s[i]);
    end
  end

  // Sequencer next state; cnt holds the number of steps still to apply.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          op_d   = cmd_op_i;
          data_d = cmd_data_i;
          if (!cmd_op_i[2]) begin
            cnt_d   = CNT_ONE;
            state_d = ST_EXEC;
          end else if (cmd_len_i == '0) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d   = cmd_len_i;
            state_d = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (abort_i || (cnt_q == CNT_ONE)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = ST_EXEC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_EXEC);
    done_d  = (state_d == ST_DONE);
  end

  // State, bank and status flops; status outputs are registered copies of the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      data_q  <= '0;
      cnt_q   <= '0;
      bank_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q_o         = bank_q;
  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_jk_bank_seq.sv
// Scoreboard bench for jk_bank_seq: per-step expected bank values are queued when a
// command is issued and popped as each EXEC edge lands.
module tb_jk_bank_seq;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] cmd_len;
  logic       abort;
  logic [7:0] q;
  logic       busy;
  logic       done;

  int         n_vec;
  int         n_err;
  logic [7:0] model_q;
  logic [7:0] exp_q[$];

  jk_bank_seq #(.WIDTH(8), .CNT_W(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i   (cmd_op),
    .cmd_data_i (cmd_data),
    .cmd_len_i  (cmd_len),
    .abort_i    (abort),
    .q_o        (q),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected summary before %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_step(input logic [2:0] op, input logic [7:0] d,
                                            input logic [7:0] cur);
    logic [7:0] r;
    case (op)
      3'd0:    r = d;
      3'd1:    r = 8'h00;
      3'd2:    r = 8'hFF;
      3'd3:    r = cur ^ d;
      3'd4:    r = cur + 8'd1;
      3'd5:    r = cur - 8'd1;
      3'd6:    r = {cur[6:0], d[0]};
      default: r = cur;
    endcase
    return r;
  endfunction

  // Issue one command from a negedge where the DUT is idle; returns at the negedge
  // where cmd_ready is high again (ready for a back-to-back command).
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, input logic [7:0] len,
                         input int abort_at, input bit noise);
    int         s;
    int         napplied;
    logic [7:0] m;
    logic [7:0] e;
    s = op[2] ? int'(len) : 1;
    napplied = (abort_at > 0 && abort_at <= s) ? abort_at - 1 : s;
    m = model_q;
    for (int k = 0; k < napplied; k++) begin
      m = model_step(op, d, m);
      exp_q.push_back(m);
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_before_cmd: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = noise;
    if (noise) begin
      cmd_op   = 3'd0;
      cmd_data = 8'h55;
      cmd_len  = 8'd9;
    end
    for (int k = 0; k < napplied; k++) begin
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_exec step %0d op %0d: got %b want 1", k, op, busy);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (q !== e) begin
        n_err++;
        $display("FAIL q_step %0d op %0d: got %h want %h", k, op, q, e);
      end
      model_q = e;
    end
    if (napplied < s) begin
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_abort_cycle: got %b want 1", busy);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    cmd_valid = 1'b0;
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0 || q !== model_q) begin
      n_err++;
      $display("FAIL done_cycle op %0d: done/busy/ready/q got %b%b%b/%h want 100/%h",
               op, done, busy, cmd_ready, q, model_q);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || q !== model_q) begin
      n_err++;
      $display("FAIL after_done op %0d: done/ready/busy/q got %b%b%b/%h want 010/%h",
               op, done, cmd_ready, busy, q, model_q);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_data = 8'h00;
    cmd_len = 8'd0;
    abort = 1'b0;
    model_q = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++;
    if (q !== 8'h00 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: q/ready/busy/done got %h/%b%b%b want 00/100",
               q, cmd_ready, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (q !== 8'h00 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_idle: q/ready got %h/%b want 00/1", q, cmd_ready);
    end
  endtask

  task automatic test_load();
    run_cmd(3'd0, 8'hA5, 8'd0, 0, 1'b0);
  endtask

  task automatic test_count_up();
    run_cmd(3'd0, 8'hFE, 8'd0, 0, 1'b0);
    run_cmd(3'd4, 8'h00, 8'd3, 0, 1'b0);
  endtask

  task automatic test_count_down_toggle();
    run_cmd(3'd0, 8'h01, 8'd0, 0, 1'b0);
    run_cmd(3'd5, 8'h00, 8'd2, 0, 1'b0);
    run_cmd(3'd3, 8'h0F, 8'd0, 0, 1'b0);
    n_vec++;
    if (q !== 8'hF0) begin
      n_err++;
      $display("FAIL toggle_result: got %h want f0", q);
    end
  endtask

  task automatic test_shift_zero_len();
    run_cmd(3'd0, 8'h81, 8'd0, 0, 1'b0);
    run_cmd(3'd6, 8'h01, 8'd2, 0, 1'b0);
    run_cmd(3'd4, 8'h00, 8'd0, 0, 1'b0);
    n_vec++;
    if (q !== 8'h07) begin
      n_err++;
      $display("FAIL zero_len_q: got %h want 07", q);
    end
  endtask

  task automatic test_single_ops();
    run_cmd(3'd2, 8'h00, 8'd5, 0, 1'b0);
    run_cmd(3'd1, 8'hFF, 8'd7, 0, 1'b0);
    run_cmd(3'd3, 8'h3C, 8'd0, 0, 1'b0);
    run_cmd(3'd7, 8'hFF, 8'd3, 0, 1'b0);
    run_cmd(3'd5, 8'h00, 8'd1, 0, 1'b0);
  endtask

  task automatic test_abort();
    run_cmd(3'd1, 8'h00, 8'd0, 0, 1'b0);
    run_cmd(3'd4, 8'h00, 8'd10, 4, 1'b0);
    n_vec++;
    if (q !== 8'h03) begin
      n_err++;
      $display("FAIL abort_q: got %h want 03", q);
    end
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (q !== 8'h03 || done !== 1'b0 || cmd_ready !== 1'b1) begin
        n_err++;
        $display("FAIL idle_after_abort %0d: q/done/ready got %h/%b%b want 03/01",
                 i, q, done, cmd_ready);
      end
    end
    abort = 1'b0;
    run_cmd(3'd4, 8'h00, 8'd2, 2, 1'b0);
    run_cmd(3'd7, 8'h00, 8'd4, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [7:0] d;
    logic [7:0] len;
    for (int i = 0; i < 16; i++) begin
      op  = 3'($urandom_range(0, 7));
      d   = 8'($urandom_range(0, 255));
      len = 8'($urandom_range(0, 5));
      run_cmd(op, d, len, 0, ($urandom_range(0, 1) == 1));
    end
    run_cmd(3'd4, 8'h00, 8'd255, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    run_cmd(3'd1, 8'h00, 8'd0, 0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op = 3'd4;
    cmd_data = 8'h00;
    cmd_len = 8'd10;
    @(negedge clk);
    cmd_op = 3'd0;
    cmd_data = 8'h55;
    repeat (2) @(negedge clk);
    n_vec++;
    if (q !== 8'h02 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL valid_while_busy: q/busy got %h/%b want 02/1", q, busy);
    end
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (q !== 8'h00 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: q/ready/busy/done got %h/%b%b%b want 00/100",
               q, cmd_ready, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_q = 8'h00;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || q !== 8'h00 || cmd_ready !== 1'b1) begin
        n_err++;
        $display("FAIL after_reset_mid %0d: done/q/ready got %b/%h/%b want 0/00/1",
                 i, done, q, cmd_ready);
      end
    end
    run_cmd(3'd0, 8'h3C, 8'd0, 0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_load();
    test_count_up();
    test_count_down_toggle();
    test_shift_zero_len();
    test_single_ops();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
